// File: rtl/dz_scan_disp.sv
// Row-scan driver for an 8x8 red/green dot matrix: one decimal digit, selectable
// colour, optional blinking, frame-synchronous digit updates and per-row anti-ghost blanking.
module dz_scan_disp #(
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYC    = 2,
    parameter int BLINK_FRAMES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] num,
    input  logic [1:0] color,
    input  logic       blink,
    input  logic       load,
    output logic [7:0] row,
    output logic [7:0] colr,
    output logic [7:0] colg,
    output logic       frame_start
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_LIM = DIV_W'(BLANK_CYC);
    localparam logic [FC_W-1:0]  FC_LAST   = FC_W'(BLINK_FRAMES - 1);

    logic [DIV_W-1:0] div;
    logic [2:0]       row_idx;
    logic [FC_W-1:0]  frame_cnt;
    logic             blink_phase;

    logic [3:0] pend_num,   act_num;
    logic [1:0] pend_color, act_color;
    logic       pend_blink, act_blink;

    logic       div_wrap;
    logic       frame_end;
    logic [7:0] glyph;
    logic       show;

    // Each glyph is packed row 0 in the top byte down to row 7 in the bottom byte.
    function automatic logic [7:0] font_row(input logic [3:0] digit, input logic [2:0] r);
        logic [63:0] g;
        case (digit)
            4'd0:    g = 64'h003C666E7666663C;
            4'd1:    g = 64'h001838181818187E;
            4'd2:    g = 64'h003C66060C30607E;
            4'd3:    g = 64'h003C66061C06663C;
            4'd4:    g = 64'h000C1C2C4C7E0C0C;
            4'd5:    g = 64'h007E607C0606663C;
            4'd6:    g = 64'h003C60607C66663C;
            4'd7:    g = 64'h007E060C18303030;
            4'd8:    g = 64'h003C66663C66663C;
            4'd9:    g = 64'h003C66663E06063C;
            default: g = 64'h0;
        endcase
        return g[{~r, 3'b000} +: 8];
    endfunction

    always_comb begin
        div_wrap  = (div == DIV_LAST);
        frame_end = div_wrap && (row_idx == 3'd7);
        glyph     = font_row(act_num, row_idx);
        show      = (div >= BLANK_LIM) && !(act_blink && blink_phase);
    end

    // Scan position, blink timing and the pending/active double buffer.
    // A load on the frame-boundary cycle bypasses pending straight into active.
    always_ff @(posedge clk) begin
        if (rst) begin
            div         <= '0;
            row_idx     <= 3'd0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            pend_num    <= 4'hF;
            pend_color  <= 2'b00;
            pend_blink  <= 1'b0;
            act_num     <= 4'hF;
            act_color   <= 2'b00;
            act_blink   <= 1'b0;
        end else begin
            div <= div_wrap ? '0 : div + 1'b1;
            if (div_wrap)
                row_idx <= row_idx + 3'd1;
            if (load) begin
                pend_num   <= num;
                pend_color <= color;
                pend_blink <= blink;
            end
            if (frame_end) begin
                act_num   <= load ? num   : pend_num;
                act_color <= load ? color : pend_color;
                act_blink <= load ? blink : pend_blink;
                if (frame_cnt == FC_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row         <= 8'hFF;
            colr        <= 8'h00;
            colg        <= 8'h00;
            frame_start <= 1'b0;
        end else begin
            row         <= ~(8'b1 << row_idx);
            colr        <= (show && act_color[0]) ? glyph : 8'h00;
            colg        <= (show && act_color[1]) ? glyph : 8'h00;
            frame_start <= (row_idx == 3'd0) && (div == '0);
        end
    end

endmodule

// File: tb/tb_dz_scan_disp.sv
// Self-checking bench for dz_scan_disp: directed plus random loads, compared every
// cycle against a frame-level reference model of the display.
module tb_dz_scan_disp;

    localparam int SCAN_DIV     = 4;
    localparam int BLANK_CYC    = 1;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME_LEN    = 8 * SCAN_DIV;

    localparam logic [7:0] FONT [10][8] = '{
        '{8'h00, 8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C},
        '{8'h00, 8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E},
        '{8'h00, 8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E},
        '{8'h00, 8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C},
        '{8'h00, 8'h0C, 8'h1C, 8'h2C, 8'h4C, 8'h7E, 8'h0C, 8'h0C},
        '{8'h00, 8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C},
        '{8'h00, 8'h3C, 8'h60, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h3C},
        '{8'h00, 8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30},
        '{8'h00, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C},
        '{8'h00, 8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h06, 8'h3C}
    };

    logic       clk;
    logic       rst;
    logic [3:0] num;
    logic [1:0] color;
    logic       blink;
    logic       load;
    logic [7:0] row;
    logic [7:0] colr;
    logic [7:0] colg;
    logic       frame_start;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: position within the frame, frames completed, and the two buffers.
    int         m_pos    = 0;
    int         m_frames = 0;
    logic [3:0] m_pend_num   = 4'hF, m_act_num   = 4'hF;
    logic [1:0] m_pend_color = 2'b00, m_act_color = 2'b00;
    logic       m_pend_blink = 1'b0, m_act_blink = 1'b0;

    logic [7:0] exp_row, exp_colr, exp_colg;
    logic       exp_fs;

    dz_scan_disp #(
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYC   (BLANK_CYC),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .num        (num),
        .color      (color),
        .blink      (blink),
        .load       (load),
        .row        (row),
        .colr       (colr),
        .colg       (colg),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput();
        n_checks++;
        assert (row === exp_row) n_pass++;
        else $error("[TB] FAIL row: observed %h expected %h (pos %0d)", row, exp_row, m_pos);
        n_checks++;
        assert (colr === exp_colr) n_pass++;
        else $error("[TB] FAIL colr: observed %h expected %h (pos %0d)", colr, exp_colr, m_pos);
        n_checks++;
        assert (colg === exp_colg) n_pass++;
        else $error("[TB] FAIL colg: observed %h expected %h (pos %0d)", colg, exp_colg, m_pos);
        n_checks++;
        assert (frame_start === exp_fs) n_pass++;
        else $error("[TB] FAIL frame_start: observed %b expected %b (pos %0d)", frame_start, exp_fs, m_pos);
    endtask

    // Drive one cycle of inputs, predict the registered outputs, then check them after the edge.
    task automatic applyStimulus(input logic r, input logic [3:0] n, input logic [1:0] c,
                                 input logic b, input logic l);
        int         ridx;
        int         dcyc;
        logic [7:0] g;
        logic       lit;
        @(negedge clk);
        rst = r; num = n; color = c; blink = b; load = l;
        if (r) begin
            exp_row = 8'hFF; exp_colr = 8'h00; exp_colg = 8'h00; exp_fs = 1'b0;
            m_pos = 0; m_frames = 0;
            m_pend_num = 4'hF; m_pend_color = 2'b00; m_pend_blink = 1'b0;
            m_act_num  = 4'hF; m_act_color  = 2'b00; m_act_blink  = 1'b0;
        end else begin
            ridx = m_pos / SCAN_DIV;
            dcyc = m_pos % SCAN_DIV;
            g    = (m_act_num < 4'd10) ? FONT[m_act_num][ridx] : 8'h00;
            lit  = (dcyc >= BLANK_CYC) &&
                   !(m_act_blink && (((m_frames / BLINK_FRAMES) % 2) == 1));
            exp_row  = ~(8'h01 << ridx);
            exp_colr = (lit && m_act_color[0]) ? g : 8'h00;
            exp_colg = (lit && m_act_color[1]) ? g : 8'h00;
            exp_fs   = (m_pos == 0);
            if (l) begin
                m_pend_num = n; m_pend_color = c; m_pend_blink = b;
            end
            if (m_pos == FRAME_LEN - 1) begin
                m_act_num = m_pend_num; m_act_color = m_pend_color; m_act_blink = m_pend_blink;
                m_frames++;
            end
            m_pos = (m_pos + 1) % FRAME_LEN;
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic runCycles(input int cycles);
        for (int i = 0; i < cycles; i++)
            applyStimulus(1'b0, num, color, blink, 1'b0);
    endtask

    task automatic runUntil(input int pos);
        while (m_pos != pos)
            applyStimulus(1'b0, num, color, blink, 1'b0);
    endtask

    initial begin
        rst = 1'b1; num = 4'h0; color = 2'b00; blink = 1'b0; load = 1'b0;

        // Reset and idle scanning with the blank glyph.
        applyStimulus(1'b1, 4'h0, 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h0, 2'b00, 1'b0, 1'b0);
        runCycles(2 * FRAME_LEN + 3);

        // Yellow 2 loaded mid-frame appears only from the next frame.
        runUntil(13);
        applyStimulus(1'b0, 4'd2, 2'b11, 1'b0, 1'b1);
        runCycles(2 * FRAME_LEN);

        // Two loads in one frame: last one wins.
        runUntil(5);
        applyStimulus(1'b0, 4'd7, 2'b01, 1'b0, 1'b1);
        runCycles(6);
        applyStimulus(1'b0, 4'd4, 2'b10, 1'b0, 1'b1);
        runCycles(2 * FRAME_LEN);

        // Load exactly on the frame-boundary cycle.
        runUntil(FRAME_LEN - 1);
        applyStimulus(1'b0, 4'd8, 2'b01, 1'b0, 1'b1);
        runCycles(2 * FRAME_LEN);

        // Blinking green 1 over several blink periods.
        runUntil(9);
        applyStimulus(1'b0, 4'd1, 2'b10, 1'b1, 1'b1);
        runCycles(6 * FRAME_LEN);

        // Random loads, including blank glyphs and boundary-cycle coincidences.
        for (int i = 0; i < 700; i++) begin
            applyStimulus(1'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
        end

        // Blank glyph 12, then reset in the middle of row 5.
        applyStimulus(1'b0, 4'd12, 2'b11, 1'b0, 1'b1);
        runCycles(FRAME_LEN);
        runUntil(5 * SCAN_DIV + 2);
        applyStimulus(1'b1, 4'd12, 2'b11, 1'b0, 1'b0);
        runCycles(FRAME_LEN + 5);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dz_scan_disp.md
Name: dz_scan_disp

Overview:
- Parametrised row-scan driver for the 8x8 red/green dot-matrix display. Shows one decimal digit 0-9 in a selectable colour (red/green/yellow), with optional blinking.
- Digit and colour are double-buffered and change only at frame boundaries, so no frame is ever half old, half new.
- Anti-ghosting blanks the columns at the start of every row slot.
- Sits between the counter/control logic and the matrix pins.

Parameters:
SCAN_DIV, 1000, clk cycles per row slot (>=2)
BLANK_CYC, 2, cycles at start of each row slot with columns forced off (< SCAN_DIV)
BLINK_FRAMES, 32, frames per blink half-period (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
num  in  4  digit to show; 0-9 valid, 10-15 = blank glyph
color  in  2  00 off, 01 red, 10 green, 11 yellow (red+green)
blink  in  1  1 = blink enabled
load  in  1  1-cycle strobe; captures num/color/blink into pending registers
row  out  8  one-hot active-low row select; bit i = row i
colr  out  8  red column data, active-high, bit 7 = leftmost
colg  out  8  green column data, active-high
frame_start  out  1  1-cycle pulse when row 0 slot begins

Behaviour:
- Reset (rst=1 at posedge):
  - div=0, row_idx=0, frame_cnt=0, blink_phase=0.
  - Pending and active registers: num=4'hF, color=00, blink=0.
  - Outputs: row=8'hFF, colr=colg=8'h00, frame_start=0.
  - Reset mid-frame aborts the scan immediately; it restarts at row 0 after release.
- Scan counter:
  - div counts 0..SCAN_DIV-1 and wraps.
  - On wrap, row_idx advances 0..7, with 7 wrapping to 0.
- Frame boundary: the cycle where div wraps and row_idx goes 7->0. At that cycle:
  - Active registers take the pending values. If load is asserted in that same cycle, they take the current num/color/blink inputs directly.
  - frame_cnt increments.
  - When frame_cnt reaches BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
- Load:
  - load=1 overwrites the pending registers only.
  - Multiple loads within one frame: the last one wins.
- Outputs are registered, with 1-cycle latency from state (div, row_idx, active regs, blink_phase):
  - row = ~(8'b1 << row_idx).
  - glyph = font[active_num][row_idx].
  - Column gating: colr = glyph if color[0], else 0; colg = glyph if color[1], else 0.
  - Columns are forced to 0 when div < BLANK_CYC.
  - Columns are forced to 0 when active_blink=1 and blink_phase=1; rows keep scanning.
  - frame_start = 1 for exactly one cycle, in the output cycle corresponding to row_idx=0, div=0.
- Font: row 0 = 00 for every digit. Rows 1-7 in hex:
  - 0: 3C 66 6E 76 66 66 3C
  - 1: 18 38 18 18 18 18 7E
  - 2: 3C 66 06 0C 30 60 7E
  - 3: 3C 66 06 1C 06 66 3C
  - 4: 0C 1C 2C 4C 7E 0C 0C
  - 5: 7E 60 7C 06 06 66 3C
  - 6: 3C 60 60 7C 66 66 3C
  - 7: 7E 06 0C 18 30 30 30
  - 8: 3C 66 66 3C 66 66 3C
  - 9: 3C 66 66 3E 06 06 3C
  - 10-15: all rows 00.
- Frame length = 8*SCAN_DIV cycles. Blink full period = 2*BLINK_FRAMES frames.

Test Plan (SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2 unless stated):
- Reset, then release with no load -> row walks FE,FD,...,7F, each held 4 cycles; colr=colg=00 throughout; frame_start pulses every 32 cycles.
- load num=2 color=11 mid-frame -> columns stay 00 until the next frame_start. In the next frame, row 4 (row=EF) shows colr=colg=0C for 3 of its 4 cycles and 00 in the first cycle.
- load num=7 color=01, then load num=4 color=10 in the same frame -> next frame is green 4 only: row 5 colg=7E, colr=00 (no 7 is ever displayed).
- load coinciding with the frame-boundary cycle (num=8 color=01) -> applied to the frame that starts on the next cycle; row 4 colr=3C.
- blink=1, num=1, color=10 -> 2 frames with glyph shown (row 7 colg=7E), 2 frames with colg=00 while rows continue scanning; repeats.
- num=12 color=11 -> all columns 00. Assert rst mid-row 5 -> next cycle row=FF, cols=00; after release the scan restarts at row 0 and the active digit is blank.
